nibble_cls_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one registered nibble classifier between N requesters.
//  - The classifier maps 00xx->1, 01xx->2, 10xx->3, 11xx->4, and any other value to 5.
//  - Accepts one 4-bit request at a time and drives the classifier.
//  - Waits the classifier latency, then returns the 3-bit code tagged with the requester ID.
//  - Sits between the requesting client blocks and the single classifier instance.

---
 rtl/nibble_cls_arbiter.sv | 137 +++++++++++++
 tb/tb_nibble_cls_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_cls_arbiter.sv
// nibble_cls_arbiter: round-robin sequencer sharing one registered nibble
// classifier between N requesters. A grant launches the classifier for one
// cycle, waits LATENCY cycles, then holds the tagged result until it is taken.
module nibble_cls_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_valid,
   input  logic [4*N-1:0]   req_data,
   output logic [N-1:0]     req_ready,
   output logic [3:0]       cls_data,
   output logic             cls_en,
   input  logic [2:0]       cls_add,
   output logic             rsp_valid,
   output logic [IDW-1:0]   rsp_id,
   output logic [2:0]       rsp_add,
   output logic             rsp_err,
   input  logic             rsp_ready,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [3:0]       nib_q, nib_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [2:0]       rsp_add_q, rsp_add_d;
   logic             rsp_err_q, rsp_err_d;

   logic             grant_vld;
   logic [IDW-1:0]   grant_idx;
   logic             xfer;

   // Round-robin search: first pass covers rr_ptr..N-1, second pass wraps to the lowest set bit
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_vld && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
            grant_vld = 1'b1;
            grant_idx = IDW'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_vld && req_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = IDW'(i);
         end
      end
   end

   assign xfer = |(req_valid & req_ready);

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         cnt_q     <= '0;
         nib_q     <= '0;
         id_q      <= '0;
         rsp_id_q  <= '0;
         rsp_add_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         nib_q     <= nib_d;
         id_q      <= id_d;
         rsp_id_q  <= rsp_id_d;
         rsp_add_q <= rsp_add_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Next-state and datapath update; the captured nibble doubles as cls_data
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      nib_d     = nib_q;
      id_d      = id_q;
      rsp_id_d  = rsp_id_q;
      rsp_add_d = rsp_add_q;
      rsp_err_d = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               nib_d    = req_data[4*grant_idx +: 4];
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 2'(LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               rsp_add_d = cls_add;
               rsp_id_d  = id_q;
               rsp_err_d = (cls_add == 3'd0) || (cls_add > 3'd4);
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore-style control outputs plus the combinational one-hot grant
   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
      cls_en    = (state_q == ISSUE);
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
   end

   assign cls_data = nib_q;
   assign rsp_id   = rsp_id_q;
   assign rsp_add  = rsp_add_q;
   assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_nibble_cls_arbiter.sv
// Bench for nibble_cls_arbiter: LATENCY=1 instance with a registered classifier
// model and scoreboard, plus a LATENCY=3 instance fed a per-cycle changing cls_add.
module tb_nibble_cls_arbiter;
   localparam int N   = 4;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  req_valid, req_ready, cls_data;
   logic [15:0] req_data;
   logic        cls_en, rsp_valid, rsp_err, rsp_ready, busy;
   logic [2:0]  cls_add, rsp_add;
   logic [1:0]  rsp_id;

   logic [3:0]  req_valid3, req_ready3, cls_data3;
   logic [15:0] req_data3;
   logic        cls_en3, rsp_valid3, rsp_err3, rsp_ready3, busy3;
   logic [2:0]  cls_add3, rsp_add3;
   logic [1:0]  rsp_id3;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_cls_arbiter #(.N(4), .IDW(2), .LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .cls_data(cls_data), .cls_en(cls_en), .cls_add(cls_add),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_add(rsp_add), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready), .busy(busy));

   nibble_cls_arbiter #(.N(4), .IDW(2), .LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_data(req_data3),
      .req_ready(req_ready3), .cls_data(cls_data3), .cls_en(cls_en3), .cls_add(cls_add3),
      .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_add(rsp_add3), .rsp_err(rsp_err3),
      .rsp_ready(rsp_ready3), .busy(busy3));

   // Registered classifier model; force_cls selects the out-of-range default code
   logic force_cls = 1'b0;
   function automatic logic [2:0] classify(input logic [3:0] n);
      case (n[3:2])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         2'b10:   return 3'd3;
         2'b11:   return 3'd4;
         default: return 3'd5;
      endcase
   endfunction
   always @(posedge clk) cls_add <= force_cls ? 3'd5 : classify(cls_data);

   // Slow-path classifier output changes every cycle so the capture point is visible
   assign cls_add3 = cyc[2:0];

   int n_checks = 0;
   int n_fail   = 0;
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  id;
      logic [2:0]  add;
      logic        err;
      int unsigned cyc;
   } exp_t;
   exp_t        sb[$];
   int          grant_log[$];
   exp_t        mon_e;
   int          mon_g;
   logic [3:0]  last_nib = '0;
   logic        in_stall = 1'b0;
   logic [1:0]  hold_id;
   logic [2:0]  hold_add;
   logic        hold_err;

   // Monitor: push expectations on transfers, check launches, pop on response acceptance
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         in_stall = 1'b0;
      end else begin
         if (|(req_valid & req_ready)) begin
            mon_g = 0;
            for (int i = N - 1; i >= 0; i--) if (req_ready[i]) mon_g = i;
            check_eq("grant_onehot", 32'($onehot(req_ready)), 1);
            last_nib  = req_data[4*mon_g +: 4];
            mon_e.id  = 2'(mon_g);
            mon_e.add = force_cls ? 3'd5 : ({1'b0, last_nib[3:2]} + 3'd1);
            mon_e.err = force_cls;
            mon_e.cyc = cyc;
            sb.push_back(mon_e);
            grant_log.push_back(mon_g);
         end
         if (cls_en) check_eq("cls_data", cls_data, last_nib);
         if (rsp_valid) begin
            check_eq("ready_in_resp", req_ready, 0);
            if (sb.size() == 0) begin
               check_eq("unexpected_rsp", rsp_valid, 0);
            end else begin
               if (in_stall) begin
                  check_eq("hold_id", rsp_id, hold_id);
                  check_eq("hold_add", rsp_add, hold_add);
                  check_eq("hold_err", rsp_err, hold_err);
               end else begin
                  check_eq("rsp_latency", cyc - sb[0].cyc, LAT + 2);
               end
               if (rsp_ready) begin
                  mon_e = sb.pop_front();
                  check_eq("rsp_id", rsp_id, mon_e.id);
                  check_eq("rsp_add", rsp_add, mon_e.add);
                  check_eq("rsp_err", rsp_err, mon_e.err);
                  in_stall = 1'b0;
               end else begin
                  in_stall = 1'b1;
                  hold_id  = rsp_id;
                  hold_add = rsp_add;
                  hold_err = rsp_err;
               end
            end
         end
      end
   end

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check_eq(tag, busy, 0);
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_req_ready"}, req_ready, 0);
      check_eq({tag, "_cls_data"}, cls_data, 0);
      check_eq({tag, "_cls_en"}, cls_en, 0);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      check_eq({tag, "_rsp_id"}, rsp_id, 0);
      check_eq({tag, "_rsp_add"}, rsp_add, 0);
      check_eq({tag, "_rsp_err"}, rsp_err, 0);
      check_eq({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int base);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (grant_log.size() > base) break;
      end
   endtask

   task automatic do_req(input int id, input logic [3:0] nib);
      int base;
      base = grant_log.size();
      @(posedge clk); #1;
      req_data[4*id +: 4] = nib;
      req_valid = '0;
      req_valid[id] = 1'b1;
      wait_grant(base);
      req_valid = '0;
      check_eq("req_accepted", grant_log.size(), base + 1);
      wait_idle("req_done");
   endtask

   task automatic run_l3(input int id, input int pre);
      int unsigned acc, en, v;
      logic [2:0]  ex;
      repeat (pre) @(posedge clk);
      #1;
      req_valid3 = '0;
      req_valid3[id] = 1'b1;
      req_data3[4*id +: 4] = 4'h9;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (|req_ready3) break;
      end
      acc = cyc;
      check_eq("l3_grant", req_ready3, 1 << id);
      @(posedge clk); #1;
      req_valid3 = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (cls_en3) break;
      end
      en = cyc;
      check_eq("l3_issue", en - acc, 1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid3) break;
      end
      check_eq("l3_latency", cyc - acc, 5);
      v  = en + 3;
      ex = v[2:0];
      check_eq("l3_rsp_add", rsp_add3, ex);
      check_eq("l3_rsp_err", rsp_err3, (ex == 3'd0) || (ex > 3'd4));
      check_eq("l3_rsp_id", rsp_id3, id);
      @(negedge clk);
      check_eq("l3_one_cycle", rsp_valid3, 0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
      req_valid3 = '0; req_data3 = '0; rsp_ready3 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_idle_zero("reset");

      // Reset while in WAIT drops the request and restores rr_ptr to 0
      do_req(1, 4'h2);
      @(posedge clk); #1;
      req_data[15:12] = 4'h5;
      req_valid = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (|req_ready) break;
      end
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_idle_zero("rst_wait");
      repeat (6) begin
         @(negedge clk);
         check_eq("no_rsp_after_rst", rsp_valid, 0);
      end
      @(posedge clk); #1;
      req_data = 16'h4321;
      req_valid = 4'b1111;
      @(negedge clk);
      check_eq("rr_after_rst", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid = '0;
      wait_idle("rr_done");

      // Single request from requester 2
      @(posedge clk); #1;
      req_data[11:8] = 4'hB;
      req_valid = 4'b0100;
      @(negedge clk);
      check_eq("single_ready", req_ready, 4'b0100);
      @(negedge clk);
      check_eq("single_ready_drop", req_ready, 0);
      check_eq("single_cls_en", cls_en, 1);
      check_eq("single_cls_data", cls_data, 4'hB);
      @(posedge clk); #1 req_valid = '0;
      wait_idle("single_done");

      // Fairness with all requesters active
      do_reset();
      req_data = {4'hF, 4'h9, 4'h6, 4'h1};
      req_valid = 4'b1111;
      base = grant_log.size();
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (grant_log.size() >= base + 5) break;
      end
      req_valid = '0;
      check_eq("fair_count", grant_log.size(), base + 5);
      for (int k = 0; k < 5; k++)
         if (base + k < grant_log.size()) check_eq("fair_order", grant_log[base+k], k % 4);
      wait_idle("fair_done");

      // Back-pressure in RESP
      rsp_ready = 1'b0;
      req_data = {4'hC, 4'hA, 4'h7, 4'h3};
      base = grant_log.size();
      @(posedge clk); #1 req_valid = 4'b0010;
      wait_grant(base);
      req_valid = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) break;
      end
      req_valid = 4'b1111;
      repeat (5) begin
         @(posedge clk); #1;
         check_eq("bp_valid", rsp_valid, 1);
         check_eq("bp_no_grant", req_ready, 0);
      end
      base = grant_log.size();
      rsp_ready = 1'b1;
      wait_grant(base);
      req_valid = '0;
      check_eq("bp_next_count", grant_log.size(), base + 1);
      check_eq("bp_next_grant", grant_log[grant_log.size()-1], 2);
      wait_idle("bp_done");

      // Out-of-range classifier code
      force_cls = 1'b1;
      do_req(0, 4'h3);
      force_cls = 1'b0;
      do_req(3, 4'h8);

      // LATENCY=3 capture timing
      run_l3(3, 1);
      run_l3(0, 2);
      run_l3(1, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
